// File: rtl/relu_backprop.sv
// ReLU backward gate: forward values leave one derivative mask bit in a FIFO, and gradients are gated in the same order.
// Optional build macro RELU_BWD_LEAKY_EN: negative-side gradients become grad_in >>> LEAK_SHIFT instead of zero.
module relu_backprop #(
    parameter int N          = 8,
    parameter int DEPTH      = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       fwd_valid,
    output logic                       fwd_ready,
    input  logic [N-1:0]               fwd_in,
    input  logic                       grad_in_valid,
    output logic                       grad_in_ready,
    input  logic [N-1:0]               grad_in,
    output logic                       grad_out_valid,
    input  logic                       grad_out_ready,
    output logic [N-1:0]               grad_out,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LEAK_SHIFT < 0 || LEAK_SHIFT >= N) begin : g_param_check
        $error("relu_backprop: DEPTH must be a power of two >= 2 and LEAK_SHIFT in [0, N-1]");
    end

    logic [DEPTH-1:0] mask_q, mask_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             grad_out_valid_q, grad_out_valid_d;
    logic [N-1:0]     grad_out_q, grad_out_d;

    logic             push;
    logic             pop;
    logic             mask_bit;
    logic [N-1:0]     gated;

    // Only the sign bit of a forward value matters for the derivative.
    logic             unused_fwd_bits;
    assign unused_fwd_bits = ^fwd_in[N-2:0];

    assign fwd_ready      = (count_q != CW'(DEPTH));
    assign grad_in_ready  = (count_q != '0) && (!grad_out_valid_q || grad_out_ready);
    assign push           = fwd_valid && fwd_ready;
    assign pop            = grad_in_valid && grad_in_ready;
    assign mask_bit       = mask_q[rd_ptr_q];

    assign grad_out_valid = grad_out_valid_q;
    assign grad_out       = grad_out_q;
    assign count          = count_q;

    always_comb begin
        gated = grad_in;
        if (!mask_bit) begin
`ifdef RELU_BWD_LEAKY_EN
            gated = $signed(grad_in) >>> LEAK_SHIFT;
`else
            gated = '0;
`endif
        end
    end

    always_comb begin
        mask_d           = mask_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        grad_out_valid_d = grad_out_valid_q;
        grad_out_d       = grad_out_q;

        if (clear) begin
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
            grad_out_valid_d = 1'b0;
            grad_out_d       = '0;
        end else begin
            if (push) begin
                mask_d[wr_ptr_q] = ~fwd_in[N-1];
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d         = rd_ptr_q + 1'b1;
                grad_out_valid_d = 1'b1;
                grad_out_d       = gated;
            end else if (grad_out_ready) begin
                grad_out_valid_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q           <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            grad_out_valid_q <= 1'b0;
            grad_out_q       <= '0;
        end else begin
            mask_q           <= mask_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            grad_out_valid_q <= grad_out_valid_d;
            grad_out_q       <= grad_out_d;
        end
    end
endmodule
